// File: rtl/maquina_maluca.sv
// Coffee-machine sequencing FSM: one start request walks power-on, water check/refill,
// grind, filter, stir, tamp and extraction, then returns to idle.
module maquina_maluca (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE                = 4'd1,
        LIGAR_MAQUINA       = 4'd2,
        VERIFICAR_AGUA      = 4'd3,
        ENCHER_RESERVATORIO = 4'd4,
        MOER_CAFE           = 4'd5,
        COLOCAR_NO_FILTRO   = 4'd6,
        PASSAR_AGITADOR     = 4'd7,
        TAMPEAR             = 4'd8,
        REALIZAR_EXTRACAO   = 4'd9
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_agua_cheia;
    logic   w_agua_cheia_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_agua_cheia <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_agua_cheia <= w_agua_cheia_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_agua_cheia_next = r_agua_cheia;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = LIGAR_MAQUINA;
            end
            // Wait for start to drop so a held request brews only once.
            LIGAR_MAQUINA: begin
                if (!start) w_state_next = VERIFICAR_AGUA;
            end
            VERIFICAR_AGUA: begin
                w_state_next = r_agua_cheia ? MOER_CAFE : ENCHER_RESERVATORIO;
            end
            ENCHER_RESERVATORIO: begin
                w_agua_cheia_next = 1'b1;
                w_state_next      = VERIFICAR_AGUA;
            end
            MOER_CAFE:         w_state_next = COLOCAR_NO_FILTRO;
            COLOCAR_NO_FILTRO: w_state_next = PASSAR_AGITADOR;
            PASSAR_AGITADOR:   w_state_next = TAMPEAR;
            TAMPEAR:           w_state_next = REALIZAR_EXTRACAO;
            REALIZAR_EXTRACAO: begin
                w_agua_cheia_next = 1'b0;
                w_state_next      = IDLE;
            end
            // Illegal codes recover to idle with the reservoir marked empty.
            default: begin
                w_agua_cheia_next = 1'b0;
                w_state_next      = IDLE;
            end
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_maquina_maluca.sv
// Self-checking bench for maquina_maluca: directed vector table, hand-written corner
// sequences, and random stimulus against a queue-based brew-path model.
module tb_maquina_maluca;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] state;

    maquina_maluca dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: idle/powered states plus a queue holding the remaining brew path.
    logic [3:0] m_state;
    bit         m_full;
    int         m_q[$];

    task automatic model_edge(input logic r, input logic s);
        if (!r) begin
            m_state = 4'd1;
            m_full  = 1'b0;
            m_q.delete();
        end else if (m_q.size() > 0) begin
            m_state = 4'(m_q.pop_front());
        end else if (m_state == 4'd1) begin
            m_state = s ? 4'd2 : 4'd1;
        end else if (m_state == 4'd2 && !s) begin
            if (m_full) m_q = '{5, 6, 7, 8, 9, 1};
            else        m_q = '{4, 3, 5, 6, 7, 8, 9, 1};
            m_full  = 1'b0;
            m_state = 4'd3;
        end
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        n_cmp++;
        if (state !== exp) begin
            n_fail++;
            $display("FAIL %s: state=%0d expected=%0d at t=%0t", name, state, exp, $time);
        end
    endtask

    // Drive inputs off-edge, let one rising edge pass, then sample 1 time unit later.
    task automatic step(input logic r, input logic s);
        @(negedge clk);
        rst_n = r;
        start = s;
        @(posedge clk);
        #1;
        model_edge(r, s);
    endtask

    typedef struct {
        logic       r;
        logic       s;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic s, input logic [3:0] e, input string n);
        vec_t v;
        v.r = r; v.s = s; v.exp = e; v.name = n;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [3:0] held;
        rst_n = 1'b0;
        start = 1'b0;

        // Reset, start ignored under reset, then a 2-edge start brew.
        add(0, 0, 1, "rst0");   add(0, 1, 1, "rst_start_ign");
        add(1, 0, 1, "idle0");  add(1, 0, 1, "idle1");
        add(1, 1, 2, "lig0");   add(1, 1, 2, "lig1");
        add(1, 0, 3, "verif");  add(1, 0, 4, "encher"); add(1, 0, 3, "verif2");
        add(1, 0, 5, "moer");   add(1, 0, 6, "filtro"); add(1, 0, 7, "agit");
        add(1, 0, 8, "tamp");   add(1, 0, 9, "extr");   add(1, 0, 1, "back_idle");
        add(1, 0, 1, "stay_idle");
        // Back-to-back: start high through the end of a brew.
        add(1, 1, 2, "b2b_lig"); add(1, 0, 3, "b2b_verif"); add(1, 0, 4, "b2b_encher");
        add(1, 0, 3, "b2b_v2");  add(1, 0, 5, "b2b_moer");  add(1, 0, 6, "b2b_filt");
        add(1, 0, 7, "b2b_agit"); add(1, 0, 8, "b2b_tamp"); add(1, 1, 9, "b2b_extr");
        add(1, 1, 1, "b2b_idle"); add(1, 1, 2, "b2b_relig");
        add(1, 0, 3, "b2b_verif3"); add(1, 0, 4, "b2b_refill"); add(1, 0, 3, "b2b_v4");
        add(1, 0, 5, "b2b_moer2"); add(1, 0, 6, "b2b_filt2");
        // Reset mid-operation at state 6, next brew must refill again.
        add(0, 0, 1, "mid_rst"); add(1, 1, 2, "post_rst_lig"); add(1, 0, 3, "post_rst_verif");
        add(1, 0, 4, "post_rst_refill"); add(1, 0, 3, "prv2"); add(1, 0, 5, "prmoer");
        add(1, 0, 6, "prfilt"); add(1, 0, 7, "pragit"); add(1, 0, 8, "prtamp");
        add(1, 0, 9, "prextr"); add(1, 0, 1, "pridle");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].s);
            check(tbl[i].name, tbl[i].exp);
            $display("vec %0d %s: rst_n=%0b start=%0b state=%0d exp=%0d",
                     i, tbl[i].name, tbl[i].r, tbl[i].s, state, tbl[i].exp);
        end

        // Long start: 6 edges high, then the normal single brew.
        for (int i = 0; i < 6; i++) begin
            step(1, 1);
            check("long_start", 4'd2);
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 0);
            check("long_seq", m_state);
            $display("long_seq %0d: state=%0d exp=%0d", i, state, m_state);
        end

        // Async immunity: pulse rst_n low strictly between edges while mid-brew.
        step(1, 1);
        step(1, 0);
        step(1, 0);
        step(1, 0);
        held = m_state;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("async_during_pulse", held);
        rst_n = 1'b1;
        #1;
        check("async_after_pulse", held);
        @(posedge clk);
        #1;
        model_edge(1, 0);
        check("async_next_edge", m_state);
        $display("async pulse: state=%0d exp=%0d", state, m_state);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, s;
            r = ($urandom_range(0, 59) != 0);
            s = ($urandom_range(0, 2) == 0);
            step(r, s);
            check("random", m_state);
            $display("rnd %0d: rst_n=%0b start=%0b state=%0d exp=%0d", i, r, s, state, m_state);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/maquina_maluca.md
# maquina_maluca

Coffee-machine sequencing FSM ("crazy machine"). It walks a fixed brewing procedure once per `start` request: power on, water check with conditional refill, grind, filter, stir, tamp, extract, then back to idle. It exposes the current state code as its only output and sits as a standalone controller driven by a single start request line.

## Interface

- No parameters. State codes are fixed localparams, listed under Operation.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, synchronous and active-low. One clock; reset is synchronous and active-low.
- `start`  input  1  brew request, level-sampled on `clk` rising edge.
- `state`  output  4  current FSM state code, driven directly from the state register.

## Operation

- State codes (4-bit):
  - IDLE=1
  - LIGAR_MAQUINA=2
  - VERIFICAR_AGUA=3
  - ENCHER_RESERVATORIO=4
  - MOER_CAFE=5
  - COLOCAR_NO_FILTRO=6
  - PASSAR_AGITADOR=7
  - TAMPEAR=8
  - REALIZAR_EXTRACAO=9
  - Codes 0 and 10–15 are illegal.
- Internal 1-bit flag `agua_cheia` (reservoir full). It is not a port.
- Transitions, one per rising edge:
  - IDLE: `start`=1 -> LIGAR_MAQUINA; else stay.
  - LIGAR_MAQUINA: stays while `start`=1. Once `start`=0 -> VERIFICAR_AGUA. A held `start` therefore starts exactly one brew.
  - VERIFICAR_AGUA: `agua_cheia`=0 -> ENCHER_RESERVATORIO; `agua_cheia`=1 -> MOER_CAFE.
  - ENCHER_RESERVATORIO: set `agua_cheia`=1 -> VERIFICAR_AGUA (unconditional, 1 cycle).
  - MOER_CAFE -> COLOCAR_NO_FILTRO -> PASSAR_AGITADOR -> TAMPEAR -> REALIZAR_EXTRACAO. Each is unconditional and lasts 1 cycle.
  - REALIZAR_EXTRACAO: clear `agua_cheia` (water consumed) -> IDLE.
  - Illegal code -> IDLE, and clear `agua_cheia`.
- `start` is ignored in every state other than IDLE and LIGAR_MAQUINA.
- No outputs besides `state`; no counters or timers.

## Timing

- Reset: `rst_n`=0 at a rising edge -> `state`=1 (IDLE) and `agua_cheia`=0 after that edge. This overrides any transition and applies mid-sequence.
- Reset is synchronous: asserting `rst_n` between edges has no effect until the next rising edge.
- `state` is registered and updates only on rising edges. There is no combinational path from `start` to `state`.
- Canonical run, cycle n = first edge sampling `start`=1 in IDLE:
  - Edge n: `state` 1 -> 2.
  - `state` stays 2 for each further edge with `start`=1.
  - First edge with `start`=0: -> 3, then on successive edges 4, 3, 5, 6, 7, 8, 9, 1.
- IDLE-to-IDLE latency with a 1-cycle `start` pulse: 10 edges.
- Brew path is never interruptible except by reset.
- Boundary cases:
  - `start` still high on return to IDLE -> a new brew begins on the next edge (2). Water is refilled again because the flag was cleared.
  - `start` asserted during reset is ignored; the first sample counts after `rst_n`=1.

## Test plan

- Reset: hold `rst_n`=0 for 2 edges with `start`=0, then release -> `state`=1 after every reset edge and stays 1 while `start`=0.
- Full brew, `start` held for 2 edges then dropped (drive off-edge):
  - IDLE, then 2 while `start` high.
  - After the drop, edge-by-edge: 3, 4, 3, 5, 6, 7, 8, 9, 1.
  - Stays 1 afterward.
- Long start: hold `start`=1 for 6 edges -> `state` remains 2 throughout; after release the sequence is identical to the previous scenario (no double brew).
- Back-to-back: keep `start`=1 through the end of a brew -> IDLE for 1 edge, then 2. The second run again visits 4 (refill) before 5.
- Reset mid-operation: assert `rst_n`=0 while `state`=6 -> `state`=1 after that edge. The next brew revisits 4, confirming the flag was cleared.
- Async-immunity: pulse `rst_n` low strictly between two edges -> `state` unaffected.
